// File: rtl/dmr_retry_buffer_pkg.sv
// Shared helpers for the DMR retry buffer.
package dmr_retry_buffer_pkg;

  // Advance a circular index, wrapping from depth-1 back to zero.
  function automatic int unsigned wrap_inc(input int unsigned value, input int unsigned depth);
    return (value == depth - 1) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/dmr_retry_buffer_popcount.sv
// Population count of a bit vector.
module dmr_retry_buffer_popcount #(
  parameter int unsigned Width      = 4,
  parameter int unsigned CountWidth = 3
) (
  input  logic [Width-1:0]      bits,
  output logic [CountWidth-1:0] count
);

  // Sum the set bits.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < Width; i++) begin
      count = count + CountWidth'(bits[i]);
    end
  end

endmodule

// File: rtl/dmr_retry_buffer.sv
// Retry buffer in front of a time-DMR pipeline: every accepted item is stored under
// an ID until the DMR output side either frees it or requests a replay.
module dmr_retry_buffer
  import dmr_retry_buffer_pkg::*;
#(
  parameter type         DataType = logic,
  parameter int unsigned IDSize   = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic [IDSize-1:0] retry_id_i,
  input  logic              retry_needed_i,
  input  logic              retry_valid_i,
  output logic              retry_ready_o,
  output logic [IDSize:0]   outstanding_o,
  output logic              retry_error_o
);

  localparam int unsigned Depth = 2 ** IDSize;

  DataType           mem_q [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic [IDSize-1:0] wr_ptr_q;
  logic              replay_valid_q;
  logic [IDSize-1:0] replay_id_q;

  logic full, alloc, retry_hs, retry_busy, free_entry, start_replay, replay_done, bad_retry;

  assign full         = busy_q[wr_ptr_q];
  assign retry_busy   = busy_q[retry_id_i];
  assign alloc        = enable_i & ~replay_valid_q & valid_i & ready_i & ~full;
  assign retry_hs     = enable_i & retry_valid_i & ~replay_valid_q;
  assign free_entry   = retry_hs & ~retry_needed_i & retry_busy;
  assign start_replay = retry_hs & retry_needed_i & retry_busy;
  assign bad_retry    = retry_hs & ~retry_busy;
  assign replay_done  = enable_i & replay_valid_q & ready_i;

  // Output muxing: bypass, replay from storage, or zero-latency pass-through.
  always_comb begin
    data_o        = data_i;
    id_o          = '0;
    valid_o       = valid_i;
    ready_o       = ready_i;
    retry_ready_o = 1'b1;
    if (enable_i) begin
      retry_ready_o = ~replay_valid_q;
      if (replay_valid_q) begin
        data_o  = mem_q[replay_id_q];
        id_o    = replay_id_q;
        valid_o = 1'b1;
        ready_o = 1'b0;
      end else begin
        id_o    = wr_ptr_q;
        valid_o = valid_i & ~full;
        ready_o = ready_i & ~full;
      end
    end
  end

  // Next busy map; a freed ID is never the allocation target in the same cycle since it is still busy.
  always_comb begin
    busy_d = busy_q;
    if (alloc)      busy_d[wr_ptr_q]   = 1'b1;
    if (free_entry) busy_d[retry_id_i] = 1'b0;
  end

  // Payload storage, written on allocation only (not reset).
  always_ff @(posedge clk_i) begin
    if (alloc) mem_q[wr_ptr_q] <= data_i;
  end

  // Bookkeeping state: busy map, write pointer, replay register, error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q         <= '0;
      wr_ptr_q       <= '0;
      replay_valid_q <= 1'b0;
      replay_id_q    <= '0;
      retry_error_o  <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      retry_error_o <= bad_retry;
      if (alloc) wr_ptr_q <= IDSize'(wrap_inc(32'(wr_ptr_q), Depth));
      if (start_replay) begin
        replay_valid_q <= 1'b1;
        replay_id_q    <= retry_id_i;
      end else if (replay_done) begin
        replay_valid_q <= 1'b0;
      end
    end
  end

  dmr_retry_buffer_popcount #(
    .Width      (Depth),
    .CountWidth (IDSize + 1)
  ) u_popcount (
    .bits  (busy_q),
    .count (outstanding_o)
  );

endmodule

// File: doc/dmr_retry_buffer.md
DMR_RETRY_BUFFER -- requirements
Module: dmr_retry_buffer

Interface
REQ-001 SHALL have parameter DataType, default logic, payload type.
REQ-002 SHALL have parameter IDSize, default 4, ID width; buffer depth is 2**IDSize.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_ni, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port enable_i, input, 1, retry buffering enable.
REQ-006 SHALL have ports data_i (input, DataType), valid_i (input, 1) and ready_o (output, 1) as the upstream handshake.
REQ-007 SHALL have ports data_o (output, DataType), id_o (output, IDSize), valid_o (output, 1) and ready_i (input, 1) as the downstream handshake toward time_DMR_start with UseExternalId=1.
REQ-008 SHALL have ports retry_id_i (input, IDSize), retry_needed_i (input, 1), retry_valid_i (input, 1) and retry_ready_o (output, 1) as the feedback from the time_DMR_end output side.
REQ-009 SHALL have port outstanding_o, output, IDSize+1, count of busy entries.
REQ-010 SHALL have port retry_error_o, output, 1, one-cycle pulse on retry for a non-busy ID.

Function
REQ-011 SHALL hold storage mem[2**IDSize] of DataType, busy bitmap busy_q, write pointer wr_ptr_q, replay register (replay_valid_q, replay_id_q).
REQ-012 SHALL, when enable_i=1 and replay_valid_q=0, drive data_o=data_i, id_o=wr_ptr_q, valid_o=valid_i & ~busy_q[wr_ptr_q], ready_o=ready_i & ~busy_q[wr_ptr_q] (zero latency).
REQ-013 SHALL, on upstream handshake, write mem[wr_ptr_q]<=data_i, set busy_q[wr_ptr_q], increment wr_ptr_q modulo 2**IDSize (wrap 2**IDSize-1 -> 0).
REQ-014 SHALL treat busy_q[wr_ptr_q]=1 as full: ready_o=0, valid_o=0, no allocation.
REQ-015 SHALL drive retry_ready_o=~replay_valid_q when enable_i=1.
REQ-016 SHALL, on retry handshake with retry_needed_i=0 and busy_q[retry_id_i]=1, clear busy_q[retry_id_i] next cycle.
REQ-017 SHALL, on retry handshake with retry_needed_i=1 and busy_q[retry_id_i]=1, set replay_valid_q=1, replay_id_q=retry_id_i; entry stays busy.
REQ-018 SHALL, while replay_valid_q=1, drive data_o=mem[replay_id_q], id_o=replay_id_q, valid_o=1, ready_o=0 (replay priority over new data).
REQ-019 SHALL clear replay_valid_q on downstream handshake while replaying; data and ID held stable until then.
REQ-020 SHALL, on retry handshake for an ID with busy_q=0, change no state and pulse retry_error_o for one cycle.
REQ-021 SHALL, on allocation and free in the same cycle, apply both; allocation never targets the freed ID that cycle (it is still busy).
REQ-022 SHALL drive outstanding_o = popcount(busy_q), updated one cycle after each allocation/free.
REQ-023 SHALL, when enable_i=0, bypass: data_o=data_i, valid_o=valid_i, ready_o=ready_i, id_o='0, retry_ready_o=1, retry inputs ignored, state frozen; enable_i changes only while outstanding_o=0 and replay_valid_q=0.

Reset
REQ-024 SHALL on rst_ni=0 asynchronously clear busy_q, wr_ptr_q, replay_valid_q, replay_id_q, retry_error_o; mem not reset.
REQ-025 SHALL after reset show outstanding_o=0, valid_o=valid_i-gated, retry_ready_o=1; reset mid-replay discards the replay and all stored entries.

Structure
REQ-026 SHALL take id width and DataType via parameters only; no new package typedefs; package constants none.
REQ-027 SHALL use the common popcount sub-module for outstanding_o; storage, pointer and replay logic stay in one module.

Verification
REQ-028 SHALL check: IDSize=2, 4 inputs 0xA1..0xA4, no retries -> id_o 0,1,2,3; fifth input stalls (ready_o=0), outstanding_o=4.
REQ-029 SHALL check: free ID 0 (retry_needed_i=0) while full -> next cycle ready_o=1, new data gets id_o=0 (wrap).
REQ-030 SHALL check: retry ID 2 with needed=1 while ready_i=0 for 3 cycles -> valid_o=1, data_o=0xA3, id_o=2 stable; upstream stalled; cleared on handshake.
REQ-031 SHALL check: second retry during active replay -> retry_ready_o=0 until replay handshake, then accepted.
REQ-032 SHALL check: retry for non-busy ID 3 -> retry_error_o pulse 1 cycle, outstanding_o unchanged.
REQ-033 SHALL check: closed loop with time_DMR_start/end and single-cycle data faults every 15-20 cycles -> every golden value delivered once without retry flag, zero mismatches.
